game_turn_ctrl: RTL and testbench

- Parametrised successor to the two-player Connect4 turn/game-status FSM.
- Sequences 2..4 players round-robin and qualifies each move against the column-full flag.
- Waits for the board datapath's win/tie result, then advances the turn or ends the game.
- Optionally skips a player who does not move within a timeout.
- Sits between the input/column-select logic and the board/win-detection datapath.

---
 rtl/game_turn_ctrl_if.sv | 34 +++
 rtl/game_turn_ctrl.sv | 162 ++++++++++++++++
 tb/tb_game_turn_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_turn_ctrl_if.sv
// Turn-controller bus: move/board handshake in, turn and status out.
// master drives the input side; slave is the controller.
interface game_turn_ctrl_if #(
    parameter int PLAYER_W = 2
);
    logic                start;
    logic                move_req;
    logic                column_full;
    logic                move_done;
    logic                win;
    logic                board_full;
    logic [PLAYER_W-1:0] current_player;
    logic [1:0]          state;
    logic [1:0]          game_status;
    logic [PLAYER_W-1:0] winner;
    logic                move_ack;
    logic                throw_again;
    logic                timeout_skip;
    logic [7:0]          turn_count;

    modport master (
        output start, move_req, column_full,
        output move_done, win, board_full,
        input  current_player, state, game_status, winner,
        input  move_ack, throw_again, timeout_skip, turn_count
    );

    modport slave (
        input  start, move_req, column_full,
        input  move_done, win, board_full,
        output current_player, state, game_status, winner,
        output move_ack, throw_again, timeout_skip, turn_count
    );
endinterface

// File: rtl/game_turn_ctrl.sv
// Round-robin turn/game-status FSM for 2..4 player Connect4.
// Define TURN_TIMEOUT_EN to skip a player who idles TIMEOUT_CYCLES.
module game_turn_ctrl #(
    parameter int NUM_PLAYERS    = 2,
    parameter int PLAYER_W       = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 16
) (
    input logic             clk,
    input logic             reset,
    game_turn_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_TURN  = 2'b01,
        S_CHECK = 2'b10,
        S_END   = 2'b11
    } state_e;

    localparam logic [1:0] GS_PLAYING = 2'b00;
    localparam logic [1:0] GS_WIN     = 2'b01;
    localparam logic [1:0] GS_TIE     = 2'b10;

    localparam logic [PLAYER_W-1:0] LAST_PLAYER =
        PLAYER_W'(NUM_PLAYERS - 1);

    function automatic logic [PLAYER_W-1:0] next_player(
        input logic [PLAYER_W-1:0] p
    );
        return (p == LAST_PLAYER) ? '0 : p + 1'b1;
    endfunction

    state_e              state_q, state_d;
    logic [PLAYER_W-1:0] player_q, player_d;
    logic [1:0]          status_q, status_d;
    logic [PLAYER_W-1:0] winner_q, winner_d;
    logic [7:0]          count_q, count_d;
    logic                ack_q, ack_d;
    logic                throw_q, throw_d;

`ifdef TURN_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               skip_q, skip_d;
    logic               expire;

    assign expire = (timer_q == TIMER_LAST);
`endif

    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        status_d = status_q;
        winner_d = winner_q;
        count_d  = count_q;
        ack_d    = 1'b0;
        throw_d  = 1'b0;
`ifdef TURN_TIMEOUT_EN
        timer_d  = timer_q;
        skip_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE, S_END: begin
                if (bus.start) begin
                    state_d  = S_TURN;
                    player_d = '0;
                    count_d  = '0;
                    status_d = GS_PLAYING;
`ifdef TURN_TIMEOUT_EN
                    timer_d  = '0;
`endif
                end
            end
            S_TURN: begin
                if (bus.move_req && !bus.column_full) begin
                    ack_d   = 1'b1;
                    state_d = S_CHECK;
`ifdef TURN_TIMEOUT_EN
                    timer_d = '0;
`endif
                end else begin
                    throw_d = bus.move_req;
`ifdef TURN_TIMEOUT_EN
                    // expiry still skips even if a rejected move arrives
                    if (expire) begin
                        skip_d   = 1'b1;
                        player_d = next_player(player_q);
                        timer_d  = '0;
                    end else begin
                        timer_d  = timer_q + 1'b1;
                    end
`endif
                end
            end
            S_CHECK: begin
                if (bus.move_done) begin
                    if (bus.win) begin
                        state_d  = S_END;
                        status_d = GS_WIN;
                        winner_d = player_q;
                    end else if (bus.board_full) begin
                        state_d  = S_END;
                        status_d = GS_TIE;
                    end else begin
                        state_d  = S_TURN;
                        player_d = next_player(player_q);
                        if (count_q != 8'hff)
                            count_d = count_q + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            player_q <= '0;
            status_q <= GS_PLAYING;
            winner_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            throw_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            status_q <= status_d;
            winner_q <= winner_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            throw_q  <= throw_d;
        end
    end

`ifdef TURN_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
            skip_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            skip_q  <= skip_d;
        end
    end

    assign bus.timeout_skip = skip_q;
`else
    assign bus.timeout_skip = 1'b0;
`endif

    assign bus.state          = state_q;
    assign bus.current_player = player_q;
    assign bus.game_status    = status_q;
    assign bus.winner         = winner_q;
    assign bus.turn_count     = count_q;
    assign bus.move_ack       = ack_q;
    assign bus.throw_again    = throw_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench: a 2-player and a 3-player controller share stimulus.
// Timeout steps run only when TURN_TIMEOUT_EN is defined.
module tb_game_turn_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic move_req = 1'b0;
    logic column_full = 1'b0;
    logic move_done = 1'b0;
    logic win = 1'b0;
    logic board_full = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_turn_ctrl_if #(.PLAYER_W(2)) b2 ();
    game_turn_ctrl_if #(.PLAYER_W(2)) b3 ();

    assign b2.start       = start;
    assign b2.move_req    = move_req;
    assign b2.column_full = column_full;
    assign b2.move_done   = move_done;
    assign b2.win         = win;
    assign b2.board_full  = board_full;
    assign b3.start       = start;
    assign b3.move_req    = move_req;
    assign b3.column_full = column_full;
    assign b3.move_done   = move_done;
    assign b3.win         = win;
    assign b3.board_full  = board_full;

    game_turn_ctrl #(
        .NUM_PLAYERS(2), .PLAYER_W(2),
        .TIMEOUT_CYCLES(8), .TIMER_W(4)
    ) u2 (
        .clk(clk), .reset(rst_n), .bus(b2)
    );

    game_turn_ctrl #(
        .NUM_PLAYERS(3), .PLAYER_W(2),
        .TIMEOUT_CYCLES(8), .TIMER_W(4)
    ) u3 (
        .clk(clk), .reset(rst_n), .bus(b3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_move(input logic cf);
        move_req = 1'b1;
        column_full = cf;
        tick();
        move_req = 1'b0;
        column_full = 1'b0;
    endtask

    task automatic do_done(input logic w, input logic bf);
        move_done = 1'b1;
        win = w;
        board_full = bf;
        tick();
        move_done = 1'b0;
        win = 1'b0;
        board_full = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_state", b3.state, 2'b00);
        chk("rst_player", b3.current_player, 0);
        chk("rst_status", b3.game_status, 2'b00);
        chk("rst_winner", b3.winner, 0);
        chk("rst_count", b3.turn_count, 0);
        chk("rst_ack", b3.move_ack, 0);
        chk("rst_throw", b3.throw_again, 0);
        chk("rst_skip", b3.timeout_skip, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", b2.state, 2'b00);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_state2", b2.state, 2'b01);
        chk("start_state3", b3.state, 2'b01);
        chk("start_player", b2.current_player, 0);

        // first accepted move
        do_move(1'b0);
        chk("ack_pulse", b2.move_ack, 1);
        chk("ack_check", b2.state, 2'b10);
        chk("ack_throw", b2.throw_again, 0);
        // move_req and start ignored in CHECK
        move_req = 1'b1;
        start = 1'b1;
        tick();
        move_req = 1'b0;
        start = 1'b0;
        chk("ack_once", b2.move_ack, 0);
        chk("chk_hold", b3.state, 2'b10);
        chk("chk_player", b3.current_player, 0);

        do_done(1'b0, 1'b0);
        chk("adv_state", b2.state, 2'b01);
        chk("adv_p2", b2.current_player, 1);
        chk("adv_p3", b3.current_player, 1);
        chk("adv_count", b2.turn_count, 1);

        // rejected move
        do_move(1'b1);
        chk("thr_pulse", b3.throw_again, 1);
        chk("thr_ack", b3.move_ack, 0);
        chk("thr_state", b3.state, 2'b01);
        chk("thr_player", b3.current_player, 1);
        tick();
        chk("thr_once", b3.throw_again, 0);

        do_move(1'b0);
        chk("ack2", b3.move_ack, 1);
        do_done(1'b0, 1'b0);
        chk("wrap_p2", b2.current_player, 0);
        chk("seq_p3", b3.current_player, 2);
        chk("cnt2", b3.turn_count, 2);

        do_move(1'b0);
        do_done(1'b0, 1'b0);
        chk("seq2_p2", b2.current_player, 1);
        chk("wrap_p3", b3.current_player, 0);
        chk("cnt3", b3.turn_count, 3);

        // win and board_full together: win wins
        do_move(1'b0);
        do_done(1'b1, 1'b1);
        chk("win_state", b2.state, 2'b11);
        chk("win_status", b2.game_status, 2'b01);
        chk("win_who2", b2.winner, 1);
        chk("win_who3", b3.winner, 0);
        chk("win_count", b2.turn_count, 3);

        // END ignores moves and board results
        move_req = 1'b1;
        move_done = 1'b1;
        board_full = 1'b1;
        tick();
        move_req = 1'b0;
        move_done = 1'b0;
        board_full = 1'b0;
        chk("end_ack", b2.move_ack, 0);
        chk("end_state", b2.state, 2'b11);
        chk("end_status", b2.game_status, 2'b01);
        chk("end_winner", b2.winner, 1);

        // restart from END
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_state", b2.state, 2'b01);
        chk("rs_player", b2.current_player, 0);
        chk("rs_status", b2.game_status, 2'b00);
        chk("rs_count", b2.turn_count, 0);

        // tie
        do_move(1'b0);
        do_done(1'b0, 1'b1);
        chk("tie_state", b3.state, 2'b11);
        chk("tie_status", b3.game_status, 2'b10);

        // asynchronous reset mid-CHECK
        start = 1'b1;
        tick();
        start = 1'b0;
        do_move(1'b0);
        do_done(1'b0, 1'b0);
        do_move(1'b0);
        chk("pre_rst_ack", b3.move_ack, 1);
        chk("pre_rst_cnt", b3.turn_count, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_state", b3.state, 2'b00);
        chk("arst_player", b3.current_player, 0);
        chk("arst_count", b3.turn_count, 0);
        chk("arst_ack", b3.move_ack, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", b3.state, 2'b00);

        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef TURN_TIMEOUT_EN
        repeat (7) tick();
        chk("to_early", b2.timeout_skip, 0);
        tick();
        chk("to_skip", b2.timeout_skip, 1);
        chk("to_player", b2.current_player, 1);
        chk("to_state", b2.state, 2'b01);
        chk("to_count", b2.turn_count, 0);
        tick();
        chk("to_once", b2.timeout_skip, 0);
        repeat (6) tick();
        do_move(1'b0);
        chk("to_ack", b3.move_ack, 1);
        chk("to_noskip", b3.timeout_skip, 0);
        chk("to_check", b3.state, 2'b10);
        do_done(1'b0, 1'b0);
        repeat (7) tick();
        do_move(1'b1);
        chk("to_rej_thr", b3.throw_again, 1);
        chk("to_rej_skip", b3.timeout_skip, 1);
        chk("to_rej_p3", b3.current_player, 0);
        chk("to_rej_p2", b2.current_player, 1);
`else
        repeat (20) tick();
        chk("nto_skip", b2.timeout_skip, 0);
        chk("nto_state", b2.state, 2'b01);
        chk("nto_player", b2.current_player, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
